alu181_nibble_seq: RTL and testbench

- Sequencer that runs WIDTH-bit ALU operations through a single external 4-bit 74181-style combinational slice, one nibble per clock, LSB nibble first.
- Captures the slice result into a wide result register and ripples the carry between nibbles in a register.
- Presents a valid/ready command interface upstream and a valid/ready result interface downstream.
- Sits between the instruction/control logic and the shared 4-bit slice, so the narrow slice can serve wide operands.

---
 rtl/alu181_nibble_seq.sv | 163 ++++++++++++++++
 tb/tb_alu181_nibble_seq.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu181_nibble_seq.sv
// ---------------------------------------------------------------------------
// alu181_nibble_seq
//
// Runs WIDTH-bit ALU operations through one external 4-bit 74181-style
// combinational slice. Each operation takes one nibble per clock, starting
// with the least significant nibble. The carry between nibbles is kept in a
// register, and each slice result is written into a wide result register.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready     upstream command handshake
//   cmd_s, cmd_m        slice function select and mode (1 = logic, 0 = arith)
//   cmd_ci              carry into nibble 0 (ignored in logic mode)
//   cmd_a, cmd_b        WIDTH-bit operands
//   res_valid/ready     downstream result handshake
//   res_y, res_co       WIDTH-bit result and carry out of the top nibble
//   res_zero            res_y == 0
//   alu_s/m/ci/a/b      drive to the shared slice (parked outside RUN)
//   alu_y, alu_co       combinational return from the slice
// ---------------------------------------------------------------------------
module alu181_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_s,
    input  logic             cmd_m,
    input  logic             cmd_ci,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_y,
    output logic             res_co,
    output logic             res_zero,

    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_ci,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_y,
    input  logic             alu_co
);

    localparam int NIB   = WIDTH / 4;
    // A one-nibble build still needs a 1-bit index to keep the ports legal.
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [IDX_W-1:0]      idx;
    logic                  carry;
    logic [3:0]            op_s;
    logic                  op_m;
    logic [NIB-1:0][3:0]   op_a;
    logic [NIB-1:0][3:0]   op_b;
    logic [NIB-1:0][3:0]   res_nib;

    // ------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nx = state;
        alu_s    = 4'd0;
        alu_m    = 1'b1;
        alu_ci   = 1'b0;
        alu_a    = 4'd0;
        alu_b    = 4'd0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                alu_s  = op_s;
                alu_m  = op_m;
                alu_ci = carry;
                alu_a  = op_a[idx];
                alu_b  = op_b[idx];
                if (idx == LAST_IDX) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // cmd_ready is low in DONE, so a command cannot be accepted on the same
    // edge that the result drains. The next accept happens in IDLE.
    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign res_y     = res_nib;
    assign res_zero  = (res_nib == '0);

    // ------------------------------------------------------------------
    // State, operand latches, nibble index, carry ripple, result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand and result registers are reset here together
            // with the control state. An abort therefore leaves res_y at zero
            // and no stale data from the aborted operation.
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            op_s    <= 4'd0;
            op_m    <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            res_nib <= '0;
            res_co  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only. Every register samples its
            // inputs as they were before this edge.
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_s  <= cmd_s;
                        op_m  <= cmd_m;
                        op_a  <= cmd_a;
                        op_b  <= cmd_b;
                        carry <= cmd_ci & ~cmd_m;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    res_nib[idx] <= alu_y;
                    // Logic mode must never pass a carry to the next nibble.
                    carry        <= alu_co & ~op_m;
                    if (idx == LAST_IDX) begin
                        res_co <= alu_co & ~op_m;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// ---------------------------------------------------------------------------
// tb_alu181_nibble_seq
//
// Self-checking bench for alu181_nibble_seq with WIDTH = 16. A 74181
// active-high slice model drives alu_y/alu_co. The bench checks results
// against a whole-word reference model. Expected results go into a
// scoreboard queue when a command is accepted. A monitor takes them off the
// queue on every result handshake.
// ---------------------------------------------------------------------------
module tb_alu181_nibble_seq;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_s;
    logic             cmd_m;
    logic             cmd_ci;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_y;
    logic             res_co;
    logic             res_zero;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_ci;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_y;
    logic             alu_co;

    alu181_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_s     (cmd_s),
        .cmd_m     (cmd_m),
        .cmd_ci    (cmd_ci),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_co    (res_co),
        .res_zero  (res_zero),
        .alu_s     (alu_s),
        .alu_m     (alu_m),
        .alu_ci    (alu_ci),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_co    (alu_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             co;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 74181 with active-high data and carry. The arithmetic form is
    // X + Y + ci, where X and Y are the two select-gated operand terms.
    // Logic mode is the carry-free XNOR of those same terms. The carry out
    // is still produced in logic mode, as on the real part.
    function automatic logic [4:0] slice(input logic [3:0] s, input logic m, input logic ci,
                                         input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x, y;
        logic [4:0] sum;
        x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum = {1'b0, x} + {1'b0, y} + {4'd0, ci};
        return m ? {sum[4], ~(x ^ y)} : sum;
    endfunction

    always_comb {alu_co, alu_y} = slice(alu_s, alu_m, alu_ci, alu_a, alu_b);

    // Whole-word terms used by the reference model.
    function automatic logic [WIDTH-1:0] term_x(input logic [3:0] s, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return a | (b & {WIDTH{s[0]}}) | (~b & {WIDTH{s[1]}});
    endfunction

    function automatic logic [WIDTH-1:0] term_y(input logic [3:0] s, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return (a & ~b & {WIDTH{s[2]}}) | (a & b & {WIDTH{s[3]}});
    endfunction

    // Whole-word reference: one wide addition in arithmetic mode, or the
    // 74181 logic function table applied to the full word.
    function automatic exp_t ref_op(input logic [3:0] s, input logic m, input logic ci,
                                    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t       r;
        logic [WIDTH:0] sum;
        if (m) begin
            r.co = 1'b0;
            case (s)
                4'd0:  r.y = ~a;
                4'd1:  r.y = ~(a | b);
                4'd2:  r.y = ~a & b;
                4'd3:  r.y = '0;
                4'd4:  r.y = ~(a & b);
                4'd5:  r.y = ~b;
                4'd6:  r.y = a ^ b;
                4'd7:  r.y = a & ~b;
                4'd8:  r.y = ~a | b;
                4'd9:  r.y = ~(a ^ b);
                4'd10: r.y = b;
                4'd11: r.y = a & b;
                4'd12: r.y = '1;
                4'd13: r.y = a | ~b;
                4'd14: r.y = a | b;
                default: r.y = a;
            endcase
        end else begin
            sum  = {1'b0, term_x(s, a, b)} + {1'b0, term_y(s, a, b)} + {{WIDTH{1'b0}}, ci};
            r.y  = sum[WIDTH-1:0];
            r.co = sum[WIDTH];
        end
        return r;
    endfunction

    // Carry the slice should see into nibble k: the carry out of the
    // low 4*k bits of the whole-word addition.
    function automatic logic carry_in(input logic [3:0] s, input logic m, input logic ci,
                                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input int k);
        logic [WIDTH:0] mask, sum;
        if (m) return 1'b0;
        if (k == 0) return ci;
        mask = ((WIDTH+1)'(1) << (4 * k)) - (WIDTH+1)'(1);
        sum  = ({1'b0, term_x(s, a, b)} & mask) + ({1'b0, term_y(s, a, b)} & mask)
             + {{WIDTH{1'b0}}, ci};
        return sum[4 * k];
    endfunction

    // Result monitor: when a handshake is about to complete, compare the
    // presented result with the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_res_y", res_y, e.y);
                check("sb_res_co", res_co, e.co);
                check("sb_res_zero", res_zero, (e.y == '0));
            end
        end
    end

    // Random downstream back-pressure, used only in the random phase.
    always @(posedge clk) begin
        #1;
        if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end

    // Present a command, wait (bounded) for it to be accepted, and record
    // the cycle of the accepting edge. Returns 1 ns after that edge.
    task automatic issue(input logic [3:0] s, input logic m, input logic ci,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int acc);
        cmd_s = s; cmd_m = m; cmd_ci = ci; cmd_a = a; cmd_b = b;
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                sb.push_back(ref_op(s, m, ci, a, b));
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (acc < 0) check("accept_timeout", 0, 1);
    endtask

    // Called right after the accept edge. Checks the slice drive on every
    // RUN cycle, then checks the parked slice and the result in DONE.
    task automatic watch_run(input logic [3:0] s, input logic m, input logic ci,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e = ref_op(s, m, ci, a, b);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            check("run_alu_a", alu_a, a[4*k +: 4]);
            check("run_alu_b", alu_b, b[4*k +: 4]);
            check("run_alu_ci", alu_ci, carry_in(s, m, ci, a, b, k));
            check("run_alu_sm", {alu_s, alu_m}, {s, m});
            check("run_res_valid", res_valid, 0);
        end
        @(negedge clk);
        check("done_res_valid", res_valid, 1);
        check("done_cmd_ready", cmd_ready, 0);
        check("done_res_y", res_y, e.y);
        check("done_res_co", res_co, e.co);
        check("done_parked", {alu_s, alu_m, alu_ci, alu_a, alu_b}, {4'd0, 1'b1, 1'b0, 8'd0});
    endtask

    initial begin
        int t, prev, c0;
        logic [3:0]       s;
        logic             m, ci;
        logic [WIDTH-1:0] a, b;
        exp_t             e;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_s = '0; cmd_m = 1'b0; cmd_ci = 1'b0;
        cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res", {res_y, res_co}, 0);
        check("rst_parked", {alu_s, alu_m, alu_ci, alu_a, alu_b}, {4'd0, 1'b1, 1'b0, 8'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: 0x1234 + 0x0FFF
        issue(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h0FFF, t);
        watch_run(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h0FFF);
        check("t1_y_zero_co", {res_y, res_zero, res_co}, {16'h2233, 1'b0, 1'b0});

        // 2: 0xFFFF + 1 wraps to zero with carry out
        issue(4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, t);
        watch_run(4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        check("t2_y_zero_co", {res_y, res_zero, res_co}, {16'h0000, 1'b1, 1'b1});

        // 3: logic XOR, the carry input must be masked off
        issue(4'b0110, 1'b1, 1'b1, 16'hA5A5, 16'h0FF0, t);
        watch_run(4'b0110, 1'b1, 1'b1, 16'hA5A5, 16'h0FF0);
        check("t3_y_zero_co", {res_y, res_zero, res_co}, {16'hAA55, 1'b0, 1'b0});

        // 4: back-pressure in DONE with another command waiting
        @(posedge clk); #1;
        res_ready = 1'b0;
        issue(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0F01, t);
        watch_run(4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0F01);
        cmd_s = 4'b0110; cmd_m = 1'b0; cmd_ci = 1'b1; cmd_a = 16'h5000; cmd_b = 16'h1234;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_res_valid", res_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_res_y", res_y, 16'h1001);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        c0 = cyc;
        issue(4'b0110, 1'b0, 1'b1, 16'h5000, 16'h1234, t);
        check("drain_then_accept", t, c0 + 2);
        watch_run(4'b0110, 1'b0, 1'b1, 16'h5000, 16'h1234);

        // 5: asynchronous reset during RUN nibble 2 aborts the operation
        issue(4'b1001, 1'b0, 1'b0, 16'h7777, 16'h1111, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_res_valid", res_valid, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_res", {res_y, res_co}, 0);
        check("abort_parked", {alu_s, alu_m, alu_ci, alu_a, alu_b}, {4'd0, 1'b1, 1'b0, 8'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(4'b0000, 1'b0, 1'b1, 16'hBEEF, 16'h0000, t);
        watch_run(4'b0000, 1'b0, 1'b1, 16'hBEEF, 16'h0000);
        check("post_abort_y", res_y, 16'hBEF0);

        // 6: back-to-back commands with res_ready held high
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            issue(4'($urandom), 1'($urandom), 1'($urandom), WIDTH'($urandom), WIDTH'($urandom), t);
            if (prev >= 0) check("b2b_spacing", t - prev, NIB + 2);
            prev = t;
        end

        // Random operations with random back-pressure
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            s  = 4'($urandom);
            m  = 1'($urandom);
            ci = 1'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
            issue(s, m, ci, a, b, t);
        end
        rand_ready = 0;
        @(posedge clk); #1;
        res_ready = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
